// File: rtl/sum_group_accumulator.sv
// Sums consecutive items into groups closed by up_last or max_items; emits total + count.
// Latency: result is visible the cycle after the closing item is accepted.
// Backpressure: 2-entry registered result buffer; up_ready drops only when it is full.
module sum_group_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_vld,
    output logic         push_rdy,
    input  logic [W-1:0] push_dat,
    output logic         pop_vld,
    input  logic         pop_rdy,
    output logic [W-1:0] pop_dat
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [W-1:0]  mem     [DEPTH];
    logic [W-1:0]  mem_nxt [DEPTH];
    logic [CW-1:0] entries;
    logic [CW-1:0] entries_nxt;
    logic [CW-1:0] wr_idx;
    logic          do_push;
    logic          do_pop;

    // Readiness comes straight from the occupancy register, never from pop_rdy.
    assign push_rdy = (entries != FULL);
    assign pop_vld  = (entries != '0);
    assign pop_dat  = mem[0];
    assign do_push  = push_vld && push_rdy;
    assign do_pop   = pop_vld && pop_rdy;

    // Shift-register organisation: slot 0 is always the head.
    always_comb begin
        mem_nxt     = mem;
        wr_idx      = entries;
        entries_nxt = entries + CW'(do_push) - CW'(do_pop);
        if (do_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                mem_nxt[i] = mem[i+1];
            end
            mem_nxt[DEPTH-1] = '0;
            wr_idx           = entries - CW'(1);
        end
        if (do_push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CW'(i) == wr_idx) begin
                    mem_nxt[i] = push_dat;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entries <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            entries <= entries_nxt;
            mem     <= mem_nxt;
        end
    end
endmodule

module sum_group_accumulator #(
    parameter int width       = 8,
    parameter int max_items   = 4,
    parameter int total_width = width + ((max_items > 1) ? $clog2(max_items) : 1),
    parameter int count_width = $clog2(max_items + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   up_valid,
    output logic                   up_ready,
    input  logic [width-1:0]       up_data,
    input  logic                   up_last,
    output logic                   down_valid,
    input  logic                   down_ready,
    output logic [total_width-1:0] down_data,
    output logic [count_width-1:0] down_count
);
    logic [total_width-1:0] acc;
    logic [count_width-1:0] cnt;
    logic [total_width-1:0] sum_nxt;
    logic [count_width-1:0] cnt_inc;
    logic                   accept;
    logic                   close_grp;

    assign accept    = up_valid && up_ready;
    assign close_grp = up_last || (cnt == count_width'(max_items - 1));
    assign sum_nxt   = acc + total_width'(up_data);
    assign cnt_inc   = cnt + count_width'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
        end else if (accept) begin
            if (close_grp) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= sum_nxt;
                cnt <= cnt_inc;
            end
        end
    end

    // Non-closing items also wait on push_rdy: no look-ahead on buffer space.
    sum_group_fifo #(
        .W     (total_width + count_width),
        .DEPTH (2)
    ) u_res_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (accept && close_grp),
        .push_rdy (up_ready),
        .push_dat ({sum_nxt, cnt_inc}),
        .pop_vld  (down_valid),
        .pop_rdy  (down_ready),
        .pop_dat  ({down_data, down_count})
    );
endmodule

// File: tb/tb_sum_group_accumulator.sv
// Randomised + directed scoreboard bench for sum_group_accumulator.
module tb_sum_group_accumulator;
    localparam int W  = 8;
    localparam int MX = 4;
    localparam int TW = 10;
    localparam int CW = 3;

    logic          clk = 0;
    logic          rst = 1;
    logic          up_valid = 0;
    logic          up_ready;
    logic [W-1:0]  up_data = '0;
    logic          up_last = 0;
    logic          down_valid;
    logic          down_ready = 1;
    logic [TW-1:0] down_data;
    logic [CW-1:0] down_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int exp_data[$];
    int exp_cnt[$];
    int pop_cyc[$];
    int m_sum = 0;
    int m_cnt = 0;
    bit rand_bp = 0;
    bit prev_stall = 0;
    logic [TW-1:0] prev_data;
    logic [CW-1:0] prev_count;

    sum_group_accumulator #(.width(W), .max_items(MX)) dut (
        .clk        (clk),
        .rst        (rst),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .up_data    (up_data),
        .up_last    (up_last),
        .down_valid (down_valid),
        .down_ready (down_ready),
        .down_data  (down_data),
        .down_count (down_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // Reference model: groups are plain running sums closed by last or size.
    task automatic model_accept(input int d, input bit last);
        m_sum += d;
        m_cnt++;
        if (last || m_cnt == MX) begin
            exp_data.push_back(m_sum);
            exp_cnt.push_back(m_cnt);
            m_sum = 0;
            m_cnt = 0;
        end
    endtask

    // Holds an item on the bus until accepted; returns attempts (0 on timeout).
    task automatic send(input int d, input bit last, output int tries);
        bit acc;
        tries = 0;
        up_valid = 1;
        up_data  = W'(d);
        up_last  = last;
        do begin
            @(negedge clk);
            acc = up_ready;
            @(posedge clk);
            #1;
            tries++;
        end while (!acc && tries < 300);
        if (!acc) begin
            check("send_timeout", 0, 1);
            tries = 0;
        end else begin
            model_accept(d, last);
        end
        up_valid = 0;
        up_data  = W'($urandom);
        up_last  = $urandom_range(0, 1) != 0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_data.size() != 0) && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(name, exp_data.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", int'(down_valid), 1);
                check("stall_data", int'(down_data), int'(prev_data));
                check("stall_count", int'(down_count), int'(prev_count));
            end
            if (down_valid && down_ready) begin
                pop_cyc.push_back(cyc);
                if (exp_data.size() == 0) begin
                    check("unexpected_result", int'(down_data), -1);
                end else begin
                    check("result_data", int'(down_data), exp_data.pop_front());
                    check("result_count", int'(down_count), exp_cnt.pop_front());
                end
            end
            prev_stall = down_valid && !down_ready;
            prev_data  = down_data;
            prev_count = down_count;
        end
    end

    initial begin
        int t;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("rst_down_valid", int'(down_valid), 0);
        check("rst_down_data", int'(down_data), 0);
        check("rst_down_count", int'(down_count), 0);
        check("rst_up_ready", int'(up_ready), 1);
        @(posedge clk);
        #1;

        // Basic group; result must already be valid just after the closing edge.
        send(10, 0, t); send(20, 0, t); send(30, 0, t); send(40, 0, t);
        check("latency_valid", int'(down_valid), 1);
        check("latency_data", int'(down_data), 100);
        drain("drain_basic");

        // Early close and full-scale values.
        send(255, 0, t); send(255, 1, t);
        for (int i = 0; i < 4; i++) send(255, 0, t);
        drain("drain_extremes");

        // Backpressure: two results fill the buffer, the third item waits.
        down_ready = 0;
        send(7, 1, t); send(8, 1, t);
        fork
            send(9, 1, t);
            begin
                repeat (3) @(posedge clk);
                #1;
                check("bp_up_ready", int'(up_ready), 0);
                check("bp_head", int'(down_data), 7);
                down_ready = 1;
            end
        join
        check("bp_9_held", (t > 1) ? 1 : 0, 1);
        drain("drain_bp");

        // Full throughput with single-item groups.
        pop_cyc.delete();
        for (int i = 0; i < 16; i++) begin
            send(i, 1, t);
            check("tput_no_stall", t, 1);
        end
        drain("drain_tput");
        check("tput_pops", pop_cyc.size(), 16);
        if (pop_cyc.size() == 16) check("tput_consecutive", pop_cyc[15] - pop_cyc[0], 15);

        // Asynchronous reset with a pending result and a partial group.
        down_ready = 0;
        send(1, 1, t); send(5, 0, t); send(6, 0, t);
        #2 rst = 1;
        #1;
        check("arst_down_valid", int'(down_valid), 0);
        check("arst_down_data", int'(down_data), 0);
        exp_data.delete(); exp_cnt.delete();
        m_sum = 0; m_cnt = 0;
        @(posedge clk);
        #1 rst = 0;
        down_ready = 1;
        send(3, 1, t);
        drain("drain_after_rst");

        // Fourth item carrying last closes exactly one group.
        send(1, 0, t); send(2, 0, t); send(3, 0, t); send(4, 1, t);
        send(5, 1, t);
        drain("drain_boundary");

        // Randomised traffic with random downstream stalls.
        rand_bp = 1;
        fork
            begin
                for (int i = 0; i < 300; i++) send($urandom_range(0, 255), $urandom_range(0, 3) == 0, t);
                rand_bp = 0;
            end
            while (rand_bp) begin
                @(posedge clk);
                #1;
                down_ready = $urandom_range(0, 3) != 0;
            end
        join
        down_ready = 1;
        drain("drain_random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
